systolic_ctrl: RTL and testbench

- Sequences one matrix-multiply pass on an N x N systolic array of signed PE cores.
- Each PE has a 1-cycle registered multiplier, then a registered accumulator; A values pass east and B values pass south through 1-cycle registers.
- The block clears the array and reads operand columns/rows from two buffers, one k index per cycle.
- It applies the diagonal skew, zero-pads before and after the valid data, and signals when every accumulator holds its final C[i][j].

---
 rtl/systolic_ctrl.sv | 167 ++++++++++++++++
 tb/tb_systolic_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// Pass sequencer for an N x N systolic array: clears the PEs, reads operand
// columns/rows one k per cycle, and drives skewed, zero-padded edge feeds.
module systolic_ctrl #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 8,
    parameter int K_W        = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [K_W-1:0]          k_len,
    output logic                    busy,
    output logic                    done,
    output logic                    a_rd_en,
    output logic [K_W-1:0]          a_rd_addr,
    input  logic [N*DATA_WIDTH-1:0] a_rd_data,
    output logic                    b_rd_en,
    output logic [K_W-1:0]          b_rd_addr,
    input  logic [N*DATA_WIDTH-1:0] b_rd_data,
    output logic [N*DATA_WIDTH-1:0] a_feed,
    output logic [N*DATA_WIDTH-1:0] b_feed,
    output logic                    pe_clr_n
);
    // Cycle counter spans FEED and DRAIN: at most K + 2N - 1, sized with margin.
    localparam int CW = $clog2((1 << K_W) + 2 * N + 2);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_FEED  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [CW-1:0] DRAIN_SPAN = CW'(2 * N - 1);

    logic [2:0]              state_r;
    logic [2:0]              state_s;
    logic [K_W-1:0]          k_r;
    logic [K_W-1:0]          k_s;
    logic [CW-1:0]           cnt_r;
    logic [CW-1:0]           cnt_s;
    logic [CW-1:0]           k_ext_s;
    logic                    busy_r;
    logic                    done_r;
    logic                    rd_en_r;
    logic [K_W-1:0]          addr_r;
    logic                    clr_n_r;
    logic                    vld_r;
    logic [N*DATA_WIDTH-1:0] a_lane_s;
    logic [N*DATA_WIDTH-1:0] b_lane_s;

    assign k_ext_s = CW'(k_r);

    // Next-state and counter logic for one pass.
    always_comb begin
        state_s = state_r;
        k_s     = k_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                cnt_s = {CW{1'b0}};
                if (start) begin
                    state_s = ST_CLEAR;
                    k_s     = k_len;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                cnt_s = {CW{1'b0}};
                if (k_r == {K_W{1'b0}}) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_FEED;
                end
            end
            ST_FEED: begin
                cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_r == k_ext_s - {{(CW-1){1'b0}}, 1'b1}) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_FEED;
                end
            end
            ST_DRAIN: begin
                // Last operand reaches PE(N-1,N-1) and clears both PE pipeline stages.
                cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_r == k_ext_s + DRAIN_SPAN) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            k_r     <= {K_W{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            rd_en_r <= 1'b0;
            addr_r  <= {K_W{1'b0}};
            clr_n_r <= 1'b0;
            vld_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
            rd_en_r <= (state_s == ST_FEED);
            addr_r  <= (state_s == ST_FEED) ? cnt_s[K_W-1:0] : {K_W{1'b0}};
            clr_n_r <= (state_s != ST_CLEAR);
            vld_r   <= rd_en_r;
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign a_rd_en   = rd_en_r;
    assign b_rd_en   = rd_en_r;
    assign a_rd_addr = addr_r;
    assign b_rd_addr = addr_r;
    assign pe_clr_n  = clr_n_r;

    // The buffer's registered read is the one data stage; outside valid reads feed zeros.
    assign a_lane_s = vld_r ? a_rd_data : {(N*DATA_WIDTH){1'b0}};
    assign b_lane_s = vld_r ? b_rd_data : {(N*DATA_WIDTH){1'b0}};

    assign a_feed[DATA_WIDTH-1:0] = a_lane_s[DATA_WIDTH-1:0];
    assign b_feed[DATA_WIDTH-1:0] = b_lane_s[DATA_WIDTH-1:0];

    for (genvar gi = 1; gi < N; gi++) begin : g_skew
        logic [DATA_WIDTH-1:0] a_pipe_r [gi];
        logic [DATA_WIDTH-1:0] b_pipe_r [gi];

        // Lane gi is delayed by gi stages to form the diagonal wavefront.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int d = 0; d < gi; d++) begin
                    a_pipe_r[d] <= {DATA_WIDTH{1'b0}};
                    b_pipe_r[d] <= {DATA_WIDTH{1'b0}};
                end
            end else begin
                a_pipe_r[0] <= a_lane_s[gi*DATA_WIDTH +: DATA_WIDTH];
                b_pipe_r[0] <= b_lane_s[gi*DATA_WIDTH +: DATA_WIDTH];
                for (int d = 1; d < gi; d++) begin
                    a_pipe_r[d] <= a_pipe_r[d-1];
                    b_pipe_r[d] <= b_pipe_r[d-1];
                end
            end
        end

        assign a_feed[gi*DATA_WIDTH +: DATA_WIDTH] = a_pipe_r[gi-1];
        assign b_feed[gi*DATA_WIDTH +: DATA_WIDTH] = b_pipe_r[gi-1];
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: operand buffers and a behavioural 4x4 PE array around
// the controller, driven from a table of passes with hand-computed results.
module tb_systolic_ctrl;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int KW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [KW-1:0] k_len;
    logic          busy, done, a_rd_en, b_rd_en, pe_clr_n;
    logic [KW-1:0] a_rd_addr, b_rd_addr;
    logic [N*DW-1:0] a_rd_data, b_rd_data, a_feed, b_feed;

    always #5 clk = ~clk;

    systolic_ctrl #(.N(N), .DATA_WIDTH(DW), .K_W(KW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
        .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
        .a_feed(a_feed), .b_feed(b_feed), .pe_clr_n(pe_clr_n)
    );

    typedef struct packed {
        logic [KW-1:0]     k;
        logic [3:0][31:0]  acol;
        logic [3:0][31:0]  brow;
        logic [7:0]        done_at;
        logic [15:0][15:0] c;
    } vec_t;

    vec_t vecs[5];
    logic [31:0] amem[32];
    logic [31:0] bmem[32];
    logic signed [7:0]  pa[4][4];
    logic signed [7:0]  pb[4][4];
    logic signed [15:0] pp[4][4];
    logic signed [15:0] acc[4][4];
    int n_vec = 0;
    int n_err = 0;

    // Operand buffers: one-cycle registered read, junk when not read.
    always @(posedge clk) begin
        a_rd_data <= a_rd_en ? amem[a_rd_addr] : $urandom();
        b_rd_data <= b_rd_en ? bmem[b_rd_addr] : $urandom();
    end

    function automatic logic signed [7:0] a_in(int i, int j);
        if (j == 0) return a_feed[i*DW +: DW];
        return pa[i][j-1];
    endfunction

    function automatic logic signed [7:0] b_in(int i, int j);
        if (i == 0) return b_feed[j*DW +: DW];
        return pb[i-1][j];
    endfunction

    // PE array: registered multiply, then registered accumulate; async clear.
    always @(posedge clk or negedge pe_clr_n) begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (!pe_clr_n) begin
                    pa[i][j]  <= 8'sd0;
                    pb[i][j]  <= 8'sd0;
                    pp[i][j]  <= 16'sd0;
                    acc[i][j] <= 16'sd0;
                end else begin
                    pa[i][j]  <= a_in(i, j);
                    pb[i][j]  <= b_in(i, j);
                    pp[i][j]  <= a_in(i, j) * b_in(i, j);
                    acc[i][j] <= acc[i][j] + pp[i][j];
                end
            end
        end
    end

    task automatic chk(input string name, input int rel, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at start+%0d: got %h, expected %h", name, rel, act, exp);
        end
    endtask

    task automatic set_vec(input int v, input logic [KW-1:0] k, input logic [3:0][31:0] a,
                           input logic [3:0][31:0] b, input logic [7:0] d, input int c[16]);
        vecs[v].k       = k;
        vecs[v].acol    = a;
        vecs[v].brow    = b;
        vecs[v].done_at = d;
        for (int x = 0; x < 16; x++) vecs[v].c[x] = 16'(c[x]);
    endtask

    // One pass; extra = cycle to re-pulse start, abort_at = cycle to drop rst_n (0 = never).
    task automatic run_pass(input int v, input int extra, input int abort_at);
        vec_t t;
        int kk;
        logic [31:0] ea, eb;
        logic exp_rd;
        t = vecs[v];
        for (int x = 0; x < 32; x++) begin
            amem[x] = 32'h0;
            bmem[x] = 32'h0;
        end
        for (int x = 0; x < 4; x++) begin
            amem[x] = t.acol[x];
            bmem[x] = t.brow[x];
        end
        @(posedge clk); #1;
        start = 1'b1;
        k_len = t.k;
        for (int rel = 1; rel <= int'(t.done_at) + 2; rel++) begin
            @(posedge clk); #1;
            start = (rel == extra);
            k_len = 5'd31;
            if (rel == abort_at) rst_n = 1'b0;
            @(negedge clk);
            if (rel == abort_at) begin
                chk("abort_busy", rel, 32'(busy), 32'd0);
                chk("abort_done", rel, 32'(done), 32'd0);
                chk("abort_pe_clr_n", rel, 32'(pe_clr_n), 32'd0);
                chk("abort_rd_en", rel, 32'(a_rd_en), 32'd0);
                chk("abort_a_feed", rel, a_feed, 32'd0);
                chk("abort_b_feed", rel, b_feed, 32'd0);
                break;
            end
            exp_rd = (t.k != 5'd0) && (rel >= 2) && (rel <= int'(t.k) + 1);
            chk("busy", rel, 32'(busy), 32'(rel <= int'(t.done_at)));
            chk("done", rel, 32'(done), 32'(rel == int'(t.done_at)));
            chk("pe_clr_n", rel, 32'(pe_clr_n), 32'(rel != 1));
            chk("a_rd_en", rel, 32'(a_rd_en), 32'(exp_rd));
            chk("b_rd_en", rel, 32'(b_rd_en), 32'(exp_rd));
            if (exp_rd) begin
                chk("a_rd_addr", rel, 32'(a_rd_addr), 32'(rel - 2));
                chk("b_rd_addr", rel, 32'(b_rd_addr), 32'(rel - 2));
            end
            // First cycle lane 0 carries k=0 is start+3; lane i lags by i.
            for (int i = 0; i < 4; i++) begin
                kk = rel - 3 - i;
                ea[i*8 +: 8] = (kk >= 0 && kk < int'(t.k)) ? t.acol[kk][i*8 +: 8] : 8'h00;
                eb[i*8 +: 8] = (kk >= 0 && kk < int'(t.k)) ? t.brow[kk][i*8 +: 8] : 8'h00;
            end
            chk("a_feed", rel, a_feed, ea);
            chk("b_feed", rel, b_feed, eb);
            if (rel == int'(t.done_at)) begin
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        chk($sformatf("c[%0d][%0d] vec%0d", i, j, v), rel,
                            {16'h0000, acc[i][j]}, {16'h0000, t.c[i*4+j]});
                    end
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int c_id[16]  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
        int c_z[16]   = '{default: 0};
        int c_k1[16]  = '{5, 6, 7, 8, 10, 12, 14, 16, 15, 18, 21, 24, 20, 24, 28, 32};
        int c_mix[16] = '{-2, 17, 3, 10, -1, -2, -3, -4, 5, -11, 6, 2, -3, 1, -6, -6};

        // A = identity, B[k][j] = 4k+j+1: C equals B.
        set_vec(0, 5'd4, {32'h01000000, 32'h00010000, 32'h00000100, 32'h00000001},
                {32'h100F0E0D, 32'h0C0B0A09, 32'h08070605, 32'h04030201}, 8'd14, c_id);
        // All -128: each sum is 65536, which wraps a 16-bit accumulator to 0.
        set_vec(1, 5'd4, {4{32'h80808080}}, {4{32'h80808080}}, 8'd14, c_z);
        // K=1 outer product [1,2,3,4] x [5,6,7,8].
        set_vec(2, 5'd1, {32'h0, 32'h0, 32'h0, 32'h04030201},
                {32'h0, 32'h0, 32'h0, 32'h08070605}, 8'd11, c_k1);
        // K=0: clear only, previous results must be wiped.
        set_vec(3, 5'd0, {4{32'h0}}, {4{32'h0}}, 8'd2, c_z);
        // Mixed signs, K=2.
        set_vec(4, 5'd2, {32'h0, 32'h0, 32'h01FD0003, 32'hFE02FF01},
                {32'h0, 32'h0, 32'h020005FF, 32'h04030201}, 8'd12, c_mix);

        rst_n = 1'b0;
        start = 1'b0;
        k_len = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_pe_clr_n", 0, 32'(pe_clr_n), 32'd0);
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_done", 0, 32'(done), 32'd0);
        chk("rst_rd_en", 0, {30'd0, a_rd_en, b_rd_en}, 32'd0);
        chk("rst_addr", 0, {22'd0, a_rd_addr, b_rd_addr}, 32'd0);
        chk("rst_a_feed", 0, a_feed, 32'd0);
        chk("rst_b_feed", 0, b_feed, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rel_pe_clr_n_before_edge", 0, 32'(pe_clr_n), 32'd0);
        @(posedge clk); #1;
        chk("rel_pe_clr_n_after_edge", 0, 32'(pe_clr_n), 32'd1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("idle_busy", c, 32'(busy), 32'd0);
            chk("idle_done", c, 32'(done), 32'd0);
            chk("idle_rd_en", c, {30'd0, a_rd_en, b_rd_en}, 32'd0);
            chk("idle_feeds", c, a_feed | b_feed, 32'd0);
        end

        run_pass(0, 3, 0);
        $display("note: vector 1 expects the 16-bit accumulator to wrap 65536 to 0");
        run_pass(1, 0, 0);
        run_pass(2, 11, 0);
        run_pass(3, 0, 0);
        run_pass(4, 0, 0);

        // Extra start in FEED, then reset in DRAIN: no done, then a clean pass.
        run_pass(0, 3, 8);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("post_abort_busy", c, 32'(busy), 32'd0);
            chk("post_abort_done", c, 32'(done), 32'd0);
            chk("post_abort_feeds", c, a_feed | b_feed, 32'd0);
        end
        run_pass(0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
